synch_fifo_flex: RTL

SYNCH_FIFO_FLEX -- requirements
Module: synch_fifo_flex

---
 rtl/fifo_pkg.sv | 17 +
 rtl/synch_fifo_ram.sv | 26 ++
 rtl/synch_fifo_flex.sv | 116 +++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared constants for the synch_fifo_flex family: read-mode encodings and default geometry.
package fifo_pkg;

  localparam int FIFO_WIDTH_DEF  = 32;
  localparam int FIFO_DEEPTH_DEF = 16;
  localparam int FIFO_PTR_DEF    = 4;

  // Values of the FWFT parameter
  localparam int MODE_REG  = 0;
  localparam int MODE_FWFT = 1;

  typedef enum logic {
    FWFT_OFF = 1'b0,
    FWFT_ON  = 1'b1
  } fwft_mode_e;

endpackage

// File: rtl/synch_fifo_ram.sv
// Storage for synch_fifo_flex: one clocked write port and one asynchronous read port.
// Contents are never reset; the read port has zero latency and there is no backpressure.
module synch_fifo_ram #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int PTR   = 4
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [PTR-1:0]   wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [PTR-1:0]   rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/synch_fifo_flex.sv
// Single-clock FIFO with selectable registered-read (1-cycle) or first-word-fall-through output.
// Writes while full and reads while empty are dropped and latched as sticky overflow/underflow.
module synch_fifo_flex
  import fifo_pkg::*;
#(
  parameter int FIFO_WIDTH  = FIFO_WIDTH_DEF,
  parameter int FIFO_DEEPTH = FIFO_DEEPTH_DEF,
  parameter int FIFO_PTR    = FIFO_PTR_DEF,
  parameter int FWFT        = MODE_REG
) (
  input  logic                  fifo_clk,
  input  logic                  rst,
  input  logic                  fifo_wren,
  input  logic                  fifo_rden,
  input  logic [FIFO_WIDTH-1:0] fifo_wrdata,
  input  logic                  fifo_flush,
  input  logic                  fifo_err_clr,
  input  logic [FIFO_PTR:0]     fifo_af_thresh,
  input  logic [FIFO_PTR:0]     fifo_ae_thresh,
  output logic [FIFO_WIDTH-1:0] fifo_rddata,
  output logic                  fifo_full,
  output logic                  fifo_empty,
  output logic                  fifo_almost_full,
  output logic                  fifo_almost_empty,
  output logic [FIFO_PTR:0]     fifo_room_avail,
  output logic [FIFO_PTR:0]     fifo_data_avail,
  output logic                  fifo_overflow,
  output logic                  fifo_underflow
);

  localparam logic [FIFO_PTR:0] DEPTH_C = (FIFO_PTR+1)'(FIFO_DEEPTH);

  logic [FIFO_PTR-1:0]   wr_ptr_q, wr_ptr_d;
  logic [FIFO_PTR-1:0]   rd_ptr_q, rd_ptr_d;
  logic [FIFO_PTR:0]     count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;
  logic                  wr_acc, rd_acc;
  logic [FIFO_WIDTH-1:0] ram_rd_data;

  assign wr_acc = fifo_wren && !fifo_full;
  assign rd_acc = fifo_rden && !fifo_empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Flush empties the queue but leaves the sticky error state alone
    ovf_d    = (fifo_wren && fifo_full)  || (ovf_q && !fifo_err_clr);
    udf_d    = (fifo_rden && fifo_empty) || (udf_q && !fifo_err_clr);
    if (fifo_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + FIFO_PTR'(1);
      if (rd_acc) rd_ptr_d = rd_ptr_q + FIFO_PTR'(1);
      count_d = count_q + (FIFO_PTR+1)'(wr_acc) - (FIFO_PTR+1)'(rd_acc);
    end
  end

  always_ff @(posedge fifo_clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  synch_fifo_ram #(
    .WIDTH (FIFO_WIDTH),
    .DEPTH (FIFO_DEEPTH),
    .PTR   (FIFO_PTR)
  ) u_ram (
    .clk     (fifo_clk),
    .wr_en   (wr_acc && !fifo_flush),
    .wr_addr (wr_ptr_q),
    .wr_data (fifo_wrdata),
    .rd_addr (rd_ptr_q),
    .rd_data (ram_rd_data)
  );

  generate
    if (FWFT == MODE_FWFT) begin : g_fwft
      assign fifo_rddata = fifo_empty ? '0 : ram_rd_data;
    end else begin : g_reg
      logic [FIFO_WIDTH-1:0] rddata_q;
      always_ff @(posedge fifo_clk or posedge rst) begin
        if (rst) begin
          rddata_q <= '0;
        end else if (rd_acc && !fifo_flush) begin
          rddata_q <= ram_rd_data;
        end
      end
      assign fifo_rddata = rddata_q;
    end
  endgenerate

  assign fifo_full         = (count_q == DEPTH_C);
  assign fifo_empty        = (count_q == '0);
  assign fifo_data_avail   = count_q;
  assign fifo_room_avail   = DEPTH_C - count_q;
  assign fifo_almost_full  = (count_q >= fifo_af_thresh);
  assign fifo_almost_empty = (count_q <= fifo_ae_thresh);
  assign fifo_overflow     = ovf_q;
  assign fifo_underflow    = udf_q;

endmodule
